// File: rtl/hs32_fetch.sv
// Instruction fetch/prefetch stage: in-order ibus reads, a small instruction FIFO
// tagged with PCs, and flush handling that discards stale in-flight responses.
module hs32_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        stall_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0]   pc_q;
  logic          run_q;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [OW-1:0] occ;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   addr_q     [MAX_OUT];
  logic [QW-1:0] aq_rd;
  logic [QW-1:0] aq_wr;

  logic issue;
  logic rsp;
  logic push;
  logic pop;

  // run_q holds the request low for the first cycle out of reset
  always_comb begin
    ibus_req_o  = run_q & ~flush_i
                & (32'(out_cnt) < MAX_OUT)
                & ((32'(occ) + 32'(out_cnt)) < DEPTH);
    ibus_addr_o = pc_q;
    issue       = ibus_req_o & ibus_gnt_i;
    rsp         = ibus_rvalid_i & (out_cnt != '0);
    push        = rsp & ~flush_i & (drop_cnt == '0);
    valid_o     = (occ != '0);
    pop         = valid_o & ~stall_i & ~flush_i;
    instr_o     = fifo_instr[rd_ptr];
    pc_o        = fifo_pc[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      run_q    <= 1'b0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      run_q   <= 1'b1;
      out_cnt <= out_cnt + CW'(issue) - CW'(rsp);

      // The address queue tracks every in-flight request, stale or not,
      // so it advances on all responses regardless of flush/drop.
      if (issue) begin
        addr_q[aq_wr] <= pc_q;
        aq_wr         <= (aq_wr == QW'(MAX_OUT - 1)) ? '0 : aq_wr + 1'b1;
        pc_q          <= pc_q + 32'd4;
      end
      if (rsp) begin
        aq_rd <= (aq_rd == QW'(MAX_OUT - 1)) ? '0 : aq_rd + 1'b1;
      end

      if (flush_i) begin
        occ      <= '0;
        rd_ptr   <= wr_ptr;
        pc_q     <= {flush_pc_i[31:2], 2'b00};
        drop_cnt <= out_cnt - CW'(rsp);
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= ibus_rdata_i;
          fifo_pc[wr_ptr]    <= addr_q[aq_rd];
          wr_ptr             <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        occ <= occ + OW'(push) - OW'(pop);
        if (rsp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (!rstn) ibus_rvalid_i |-> (out_cnt != '0));
`endif

endmodule
